product_bcd_display: RTL
========================

# product_bcd_display

Downstream stage of the 4x4 carry-save array multiplier. It accepts the 8-bit product over a valid/ready handshake and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed, active-low 4-digit seven-segment display from the last completed result. It is the board-level consumer of the multiplier output, P.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal ≥ 2.
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous, active-low reset.
- p_in  input  8  unsigned product from the multiplier.
- p_valid  input  1  p_in is valid this cycle.
- p_ready  output  1  block can accept p_in; high only in IDLE.
- bcd_out  output  12  last result, {hundreds, tens, ones}, 4 bits each.
- bcd_valid  output  1  one-cycle pulse when bcd_out updates.
- an  output  4  digit anodes, active-low one-hot; an[0] is the ones digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).

## Operation
- Converter FSM has three states: IDLE, CONV, DONE.
- IDLE: p_ready=1. When p_valid&&p_ready, the block latches p_in into an 8-bit shift register, clears the 12-bit BCD scratch, sets iter=0 and goes to CONV.
- CONV: p_ready=0. Each cycle, every scratch nibble ≥5 gets +3. Then {scratch, shreg} shifts left 1. iter increments. After the 8th iteration (iter==7) the FSM goes to DONE.
- DONE: bcd_out <= scratch, bcd_valid pulses, FSM returns to IDLE.
- p_valid outside IDLE is ignored. No queuing; the product is not re-sampled.
- Arithmetic: input range 0..255. Hundreds nibble ≤2. Nibbles are always 0..9 after conversion.
- Display scanner runs independently of the FSM.
  - refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, 2-bit digit select advances 0→1→2→3→0.
- Digit mapping:
  - Select 0: ones.
  - Select 1: tens.
  - Select 2: hundreds.
  - Select 3: always blank (seg=7'h7F); its anode still asserts.
- Display always shows the registered bcd_out and is never torn mid-conversion.
- Reset mid-conversion aborts the conversion. bcd_out returns to 0; no bcd_valid.

## Timing
- Handshake accepted at edge 0. CONV runs edges 1..8. bcd_out updates and bcd_valid rises at edge 9, high for exactly one cycle.
- p_ready is high again after edge 9. Throughput is one product per 10 cycles.
- If the new p_valid is already asserted in the cycle after the DONE edge, it is accepted at edge 10.
- seg/an are registered and change only on refresh wrap.
- Reset values:
  - FSM state, p_ready and outputs: FSM=IDLE, p_ready=1, bcd_out=0, bcd_valid=0.
  - Scan counters: refresh counter=0, select=0.
  - Display outputs: an=4'b1110, seg=7'b1000000 ("0"), dp=1.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit is blanked when it is 0.
  - Tens digit is blanked when hundreds and tens are both 0.
  - Ones digit is never blanked, so P=7 shows "  7".
- LEADING_ZERO_BLANK_EN undefined: all three digits are always shown, so P=7 shows "007".
- The macro affects only seg. bcd_out and the scan timing are identical in both builds.

## Structure
- Package product_disp_pkg holds:
  - FSM state typedef (IDLE/CONV/DONE).
  - SEG_BLANK=7'h7F.
  - Active-low digit patterns 0–9.
  - NUM_ITER=8.
- One sub-module, seg7_decode: combinational 4-bit BCD plus blank flag in, 7-bit active-low segments out. It is instantiated once, after the digit mux.
- Double-dabble datapath and scan counter stay in the top module.

## Test plan
- Reset check: assert rst_n=0 then release → p_ready=1, bcd_out=12'h000, an=4'b1110, seg=7'b1000000, dp=1.
- Conversion values: drive p_in=25 (5×5), 45 (9×5), 156 (12×13), 150 (15×10) and 255, each with a one-cycle p_valid.
  - Required bcd_out: 12'h025, 12'h045, 12'h156, 12'h150, 12'h255.
  - Each bcd_valid pulse is exactly 1 cycle, 9 edges after acceptance.
- Busy input ignored: accept 156, then drive p_valid with p_in=0 for cycles 1..8 → p_ready=0 throughout, result still 12'h156, next accept at the first IDLE cycle.
- Reset mid-conversion: accept 255, pull rst_n low at cycle 4 → bcd_out=0, no bcd_valid, FSM in IDLE after release.
- Scan, REFRESH_DIV=4, bcd_out=12'h045: an sequence 1110→1101→1011→0111, each held 4 cycles.
  - seg values: "5", "4", then hundreds.
  - Hundreds shows "0" in the unblanked build and 7'h7F with LEADING_ZERO_BLANK_EN.
  - Digit 3 is always 7'h7F.
- P=0, REFRESH_DIV=4: ones digit always shows "0" in both builds; tens and hundreds show "0" unblanked and are blank with LEADING_ZERO_BLANK_EN.

Source files
------------

// File: rtl/product_disp_pkg.sv
// Shared types and constants for the product-to-BCD converter and display scanner.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits on the display).
package product_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam int NUM_ITER = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; element [0] is digit 0.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Shift-add-3 correction applied to each BCD nibble before the shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/product_bcd_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank override.
// Codes above 9 decode to blank.
module seg7_decode
  import product_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      for (int i = 0; i < 10; i++) begin
        if (digit == 4'(i)) seg = SEG_DIGITS[i];
      end
    end
  end

endmodule

// File: rtl/product_bcd_display.sv
// Accepts an 8-bit product, converts it to three BCD digits by sequential double-dabble,
// and scans the last result onto a 4-digit active-low display. Macro: LEADING_ZERO_BLANK_EN.
module product_bcd_display
  import product_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  p_in,
  input  logic        p_valid,
  output logic        p_ready,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int ITER_W = $clog2(NUM_ITER);

  conv_state_t       state;
  logic [7:0]        shreg;
  logic [11:0]       scratch;
  logic [11:0]       scratch_adj;
  logic [ITER_W-1:0] iter;

  assign scratch_adj = {dd_adjust(scratch[11:8]), dd_adjust(scratch[7:4]), dd_adjust(scratch[3:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      p_ready   <= 1'b1;
      bcd_out   <= 12'h000;
      bcd_valid <= 1'b0;
      shreg     <= 8'h00;
      scratch   <= 12'h000;
      iter      <= '0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (p_valid) begin
            shreg   <= p_in;
            scratch <= 12'h000;
            iter    <= '0;
            p_ready <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          iter             <= iter + 1'b1;
          if (iter == ITER_W'(NUM_ITER - 1)) state <= DONE;
        end
        DONE: begin
          bcd_out   <= scratch;
          bcd_valid <= 1'b1;
          p_ready   <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          p_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       sel;
  logic [1:0]       sel_next;
  logic             wrap;
  logic [3:0]       an_next;
  logic [3:0]       mux_digit;
  logic             mux_blank;
  logic [6:0]       seg_dec;

  assign wrap     = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign sel_next = sel + 2'd1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_anode
    assign an_next[gi] = (sel_next != 2'(gi));
  end

  // The mux looks at the upcoming select so seg and an are loaded on the same wrap edge.
  always_comb begin
    mux_digit = 4'd0;
    mux_blank = 1'b0;
    case (sel_next)
      2'd0: mux_digit = bcd_out[3:0];
      2'd1: begin
        mux_digit = bcd_out[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        mux_blank = (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
`endif
      end
      2'd2: begin
        mux_digit = bcd_out[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        mux_blank = (bcd_out[11:8] == 4'd0);
`endif
      end
      default: mux_blank = 1'b1;
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (mux_digit),
    .blank (mux_blank),
    .seg   (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      sel         <= 2'd0;
      an          <= 4'b1110;
      seg         <= 7'b1000000;
    end else if (wrap) begin
      refresh_cnt <= '0;
      sel         <= sel_next;
      an          <= an_next;
      seg         <= seg_dec;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  assign dp = 1'b1;

endmodule
